audio_rx_ctrl: RTL
==================

# audio_rx_ctrl

Sequencing controller for the SPI audio receiver. It drives the receiver's `active` input, realigns the receiver's bit counter after stream stalls, and buffers received 16-bit samples in a FIFO. Samples are released at a fixed sample rate to the downstream PWM/DAC stage, and the block reports underrun, overflow and resync events. It sits between the receiver and the audio output in the `clk_25mhz` domain.

## Interface
- `CLK_HZ`, 25_000_000, system clock frequency.
- `SAMPLE_HZ`, 16_000, output sample rate; tick divider `DIV = CLK_HZ / SAMPLE_HZ` (integer floor, 1562 at defaults).
- `FIFO_DEPTH`, 16, sample buffer depth; power of two, ≥4.
- `PREFILL`, 8, FIFO level required before streaming; 1..FIFO_DEPTH.
- `TIMEOUT_CYCLES`, 25_000, cycles without `rx_data_ready` that trigger a resync.
- `RESYNC_CYCLES`, 64, cycles `rx_active` is held low during resync.

Ports:
- `clk_25mhz` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: user enable for the audio path.
- `rx_data_ready` in 1: one-cycle pulse from the receiver when a word is complete.
- `rx_audio` in 16: received word, valid when `rx_data_ready` = 1.
- `rx_active` out 1: drives the receiver's `active` input.
- `sample_out` out 16: current output sample.
- `sample_valid` out 1: one-cycle pulse per sample tick.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of buffered samples.
- `streaming` out 1: high while in STREAM.
- `underrun_cnt`, `overflow_cnt`, `resync_cnt` out 8 each: saturating event counters.

## Operation
- States: OFF, RESYNC, PREFILL, STREAM.
- **OFF:**
  - `rx_active`=0; FIFO flushed; tick divider, watchdog and resync counter held at 0; `sample_out`=0.
  - `enable`=1 → RESYNC.
- **RESYNC:**
  - `rx_active`=0 for exactly RESYNC_CYCLES cycles, then → PREFILL. This forces the receiver to IDLE so its bit counter restarts.
  - FIFO contents are retained.
  - Sample ticks continue: `sample_valid` pulses and `sample_out` holds its last value.
- **PREFILL:**
  - `rx_active`=1; writes accepted; ticks pulse `sample_valid` with `sample_out` held (no pop).
  - `fifo_level` ≥ PREFILL → STREAM.
- **STREAM:**
  - `rx_active`=1.
  - On each tick, pop the head to `sample_out`.
  - Tick with FIFO empty: underrun. `sample_out` holds, `underrun_cnt`++, → PREFILL.
- **Watchdog (PREFILL, STREAM):**
  - Counts cycles since the last `rx_data_ready`; cleared on each pulse and on entry to PREFILL from RESYNC.
  - Reaching TIMEOUT_CYCLES → RESYNC, `resync_cnt`++.
- **FIFO writes:**
  - `rx_data_ready`=1 in PREFILL/STREAM writes `rx_audio`. Writes in OFF/RESYNC are ignored.
  - Full and no pop in the same cycle: word dropped, `overflow_cnt`++.
  - Full with a pop in the same cycle: write accepted, level unchanged.
  - Empty with a write on the same tick cycle: counts as underrun, no bypass path.
- `enable`=0 in any state → OFF on the next edge; this has priority over all other transitions.
- Counters saturate at 255 and are cleared only by `reset`.
- FIFO pointers wrap modulo FIFO_DEPTH; `fifo_level` ranges 0..FIFO_DEPTH.

## Timing
- Reset values:
  - `rx_active`=0, `sample_out`=0, `sample_valid`=0, `fifo_level`=0, `streaming`=0, all counters 0.
  - State = OFF.
- Tick divider counts 0..DIV-1 in all non-OFF states. The tick fires when the count reaches DIV-1, so the first tick occurs DIV cycles after leaving OFF.
- Tick at edge T → `sample_valid` and the new `sample_out` are registered and visible after edge T+1; `sample_valid` is high for one cycle.
- `rx_data_ready` sampled at edge N → `fifo_level` updated after edge N.
- `rx_active` is a registered output; it changes on the edge that enters or leaves RESYNC/OFF.
- `reset` asserted mid-operation asynchronously returns all outputs to their reset values and flushes the FIFO.

## Structure
- Package `audio_pkg`: `SAMPLE_W`=16 and the `ctrl_state_t` enum (OFF, RESYNC, PREFILL, STREAM). Share with the receiver and the PWM stage.
- Sub-module `sample_fifo`: synchronous FIFO, parameters DEPTH and width, with push/pop/full/empty/level and a flush input.
- Top level holds the FSM, tick divider, watchdog, resync counter and event counters.

## Test plan
Bench parameters: CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), FIFO_DEPTH=4, PREFILL=2, TIMEOUT_CYCLES=50, RESYNC_CYCLES=8.
- **Startup:** `enable`↑ → `rx_active` low 8 cycles then high; push 0x1234 and 0x5678 → `streaming`=1; next ticks give `sample_out` 0x1234 then 0x5678.
- **Overflow:** push 5 words with no tick between pushes → `fifo_level`=4, `overflow_cnt`=1; the 5th word is never output.
- **Underrun:** stream 2 words then stop pushing → on the 3rd tick `sample_out` holds 0x5678, `underrun_cnt`=1, state PREFILL.
- **Timeout:** no `rx_data_ready` for 50 cycles in STREAM → `rx_active` low 8 cycles, `resync_cnt`=1, FIFO level retained.
- **Full with simultaneous push and pop:** FIFO full, push on a tick cycle → word accepted, level stays 4, `overflow_cnt` unchanged.
- **Disable and reset:** `enable`↓ mid-stream → next cycle `rx_active`=0, `sample_out`=0, `fifo_level`=0. `reset` pulse mid-stream → all outputs and counters 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path types: sample width, controller state encoding and
// the per-cycle event bundle reported by the receive controller.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RESYNC,
        ST_PREFILL,
        ST_STREAM
    } ctrl_state_t;

    typedef struct packed {
        logic underrun;
        logic overflow;
        logic timeout;
    } ctrl_evt_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with flush; a push on a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                   clk_25mhz,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/audio_rx_ctrl.sv
// Sequencing controller for the SPI audio receiver: resync handling,
// sample buffering and fixed-rate release to the output stage.
module audio_rx_ctrl
    import audio_pkg::*;
#(
    parameter int CLK_HZ         = 25_000_000,
    parameter int SAMPLE_HZ      = 16_000,
    parameter int FIFO_DEPTH     = 16,
    parameter int PREFILL        = 8,
    parameter int TIMEOUT_CYCLES = 25_000,
    parameter int RESYNC_CYCLES  = 64
) (
    input  logic                        clk_25mhz,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        rx_data_ready,
    input  logic [SAMPLE_W-1:0]         rx_audio,
    output logic                        rx_active,
    output logic [SAMPLE_W-1:0]         sample_out,
    output logic                        sample_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        streaming,
    output logic [7:0]                  underrun_cnt,
    output logic [7:0]                  overflow_cnt,
    output logic [7:0]                  resync_cnt
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int DW  = $clog2(DIV + 1);
    localparam int WW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW  = $clog2(RESYNC_CYCLES + 1);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RS_LAST  = RW'(RESYNC_CYCLES - 1);
    localparam logic [LW-1:0] PF_LVL   = LW'(PREFILL);

    ctrl_state_t         state;
    ctrl_state_t         state_nxt;
    ctrl_evt_t           evt;
    logic [DW-1:0]       div_cnt;
    logic [WW-1:0]       wd_cnt;
    logic [RW-1:0]       rs_cnt;
    logic                tick;
    logic                rx_window;
    logic                push_req;
    logic                pop;
    logic                flush;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_rdata;

    assign rx_window = enable &&
                       (state == ST_PREFILL || state == ST_STREAM);
    assign tick      = (state != ST_OFF) && (div_cnt == DIV_LAST);
    assign push_req  = rx_window && rx_data_ready;
    assign pop       = enable && (state == ST_STREAM) && tick && !fifo_empty;
    assign flush     = !enable || (state == ST_OFF);
    assign streaming = (state == ST_STREAM);

    // A full FIFO still takes the word when this cycle's tick frees a slot
    assign evt.overflow = push_req && fifo_full && !pop;
    assign evt.underrun = enable && (state == ST_STREAM) && tick && fifo_empty;
    assign evt.timeout  = rx_window && !rx_data_ready && (wd_cnt == WD_LAST);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .flush     (flush),
        .push      (push_req),
        .pop       (pop),
        .wdata     (rx_audio),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_OFF;
        end else begin
            unique case (state)
                ST_OFF: state_nxt = ST_RESYNC;
                ST_RESYNC: begin
                    if (rs_cnt == RS_LAST) state_nxt = ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (evt.timeout)             state_nxt = ST_RESYNC;
                    else if (fifo_level >= PF_LVL) state_nxt = ST_STREAM;
                end
                ST_STREAM: begin
                    if (evt.timeout)       state_nxt = ST_RESYNC;
                    else if (evt.underrun) state_nxt = ST_PREFILL;
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state     <= ST_OFF;
            rx_active <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_active <= (state_nxt == ST_PREFILL) ||
                         (state_nxt == ST_STREAM);
        end
    end

    // Divider free-runs through RESYNC/PREFILL so the output rate never jitters
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (flush || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (!rx_window || rx_data_ready || evt.timeout) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            rs_cnt <= '0;
        end else if (enable && state == ST_RESYNC) begin
            rs_cnt <= rs_cnt + 1'b1;
        end else begin
            rs_cnt <= '0;
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= enable && tick;
            unique case (1'b1)
                (state_nxt == ST_OFF): sample_out <= '0;
                pop:                   sample_out <= fifo_rdata;
                default:               sample_out <= sample_out;
            endcase
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
            overflow_cnt <= '0;
            resync_cnt   <= '0;
        end else begin
            if (evt.underrun) underrun_cnt <= sat_inc(underrun_cnt);
            if (evt.overflow) overflow_cnt <= sat_inc(overflow_cnt);
            if (evt.timeout)  resync_cnt   <= sat_inc(resync_cnt);
        end
    end

endmodule
